// File: rtl/rio_pkg.sv
// rio_pkg: shared constants and helpers for the RIO frame codec.
//   RIO_RX_HEADER  default header expected on received frames
//   RIO_TX_DATA    transmit header while running normally ("data")
//   RIO_TX_ESTOP   transmit header while the E-stop latch is set ("estp")
//   swap32         byte order swap between wire order and word value
//   xor_bytes      XOR of all bytes of a zero-extended vector
package rio_pkg;

  localparam logic [31:0] RIO_RX_HEADER = 32'h74697277;
  localparam logic [31:0] RIO_TX_DATA   = 32'h64617461;
  localparam logic [31:0] RIO_TX_ESTOP  = 32'h65737470;

  // Widest frame the checksum helper accepts; narrower frames are
  // zero-extended, and zero bytes do not change an XOR.
  localparam int RIO_XOR_BITS = 8192;

  function automatic logic [31:0] swap32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  function automatic logic [7:0] xor_bytes(input logic [RIO_XOR_BITS-1:0] v);
    logic [7:0] acc;
    acc = '0;
    for (int i = 0; i < RIO_XOR_BITS / 8; i++) acc ^= v[8*i +: 8];
    return acc;
  endfunction

endpackage

// File: rtl/rio_watchdog.sv
// rio_watchdog: saturating link watchdog.
//   clk_i      clock
//   rst_ni     asynchronous active-low reset (count starts saturated)
//   clear_i    restart counting from 0
//   expired_o  count has reached TIMEOUT_CYCLES
module rio_watchdog #(
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;

  // Clear has priority so a good frame arriving on the expiry cycle wins.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) cnt_d = '0;
    else if (cnt_q != LIMIT) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= LIMIT;
    else         cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/rio_frame_codec.sv
// rio_frame_codec: RIO rx frame decode / tx frame assembly.
// Optional feature macro: RIO_FRAME_CHECKSUM_EN (trailing XOR checksum byte).
// Ports:
//   sysclk, rst_n          clock, asynchronous active-low reset
//   frame_valid, rx_frame  received frame strobe and contents (MSB first on wire)
//   tx_lock, tx_frame      hold request while shifting, transmit frame
//   estop_in               external E-stop request
//   joint_feedback, process_var, din   transmit feedback sources
//   joint_freq_cmd, joint_enable, setpoint, dout   committed commands
//   timeout, error         watchdog expiry, global error
//   good_cnt, bad_cnt      wrapping frame counters
module rio_frame_codec
  import rio_pkg::*;
#(
  parameter int          JOINTS         = 5,
  parameter int          VOUTS          = 2,
  parameter int          VINS           = 1,
  parameter int          DIO_BYTES      = 1,
  parameter logic [31:0] RX_HEADER      = RIO_RX_HEADER,
  parameter int          TIMEOUT_CYCLES = 5000000,
  localparam int EN_BYTES  = (JOINTS + 7) / 8,
  localparam int RX_BITS   = 32*(1+JOINTS+VOUTS) + 8*(EN_BYTES+DIO_BYTES),
  localparam int TX_BITS   = 32*(1+JOINTS+VINS) + 8*DIO_BYTES,
  localparam int BASE_BITS = (((RX_BITS > TX_BITS) ? RX_BITS : TX_BITS) + 7) / 8 * 8,
`ifdef RIO_FRAME_CHECKSUM_EN
  localparam int FRAME_BITS = BASE_BITS + 8
`else
  localparam int FRAME_BITS = BASE_BITS
`endif
) (
  input  logic                   sysclk,
  input  logic                   rst_n,
  input  logic                   frame_valid,
  input  logic [FRAME_BITS-1:0]  rx_frame,
  input  logic                   tx_lock,
  output logic [FRAME_BITS-1:0]  tx_frame,
  input  logic                   estop_in,
  input  logic [32*JOINTS-1:0]   joint_feedback,
  input  logic [32*VINS-1:0]     process_var,
  input  logic [8*DIO_BYTES-1:0] din,
  output logic [32*JOINTS-1:0]   joint_freq_cmd,
  output logic [JOINTS-1:0]      joint_enable,
  output logic [32*VOUTS-1:0]    setpoint,
  output logic [8*DIO_BYTES-1:0] dout,
  output logic                   timeout,
  output logic                   error,
  output logic [15:0]            good_cnt,
  output logic [15:0]            bad_cnt
);

  // Bit offset just below the last 32-bit rx field; enable and dout bytes follow.
  localparam int RX_BYTES_TOP = FRAME_BITS - 32*(1+JOINTS+VOUTS);
  localparam int TX_DIN_TOP   = BASE_BITS - 32*(1+JOINTS+VINS);

  logic hdr_ok, csum_ok, good, bad, wd_expired;
  logic unused_rx;

  logic [32*JOINTS-1:0]   freq_rx, freq_q, freq_d;
  logic [JOINTS-1:0]      en_rx, en_q, en_d;
  logic [32*VOUTS-1:0]    sp_rx, sp_q, sp_d;
  logic [8*DIO_BYTES-1:0] dout_rx, dout_q, dout_d;
  logic [15:0]            good_q, good_d, bad_q, bad_d;
  logic                   estop_q, estop_d;
  logic [BASE_BITS-1:0]   tx_body;
  logic [FRAME_BITS-1:0]  tx_q, tx_d;

  assign unused_rx = ^rx_frame;

  assign hdr_ok = (swap32(rx_frame[FRAME_BITS-1 -: 32]) == RX_HEADER);
`ifdef RIO_FRAME_CHECKSUM_EN
  assign csum_ok = (xor_bytes(RIO_XOR_BITS'(rx_frame[FRAME_BITS-1:8])) == rx_frame[7:0]);
`else
  assign csum_ok = 1'b1;
`endif
  assign good = frame_valid & hdr_ok & csum_ok;
  assign bad  = frame_valid & ~good;

  always_comb begin : rx_unpack
    freq_rx = '0;
    en_rx   = '0;
    sp_rx   = '0;
    dout_rx = '0;
    for (int k = 0; k < JOINTS; k++)
      freq_rx[32*k +: 32] = swap32(rx_frame[FRAME_BITS-1-32*(1+k) -: 32]);
    for (int k = 0; k < VOUTS; k++)
      sp_rx[32*k +: 32] = swap32(rx_frame[FRAME_BITS-1-32*(1+JOINTS+k) -: 32]);
    // Enable field is big-endian across its bytes with joint 0 at the LSB.
    for (int k = 0; k < JOINTS; k++)
      en_rx[k] = rx_frame[RX_BYTES_TOP-8*EN_BYTES+k];
    dout_rx = rx_frame[RX_BYTES_TOP-8*EN_BYTES-1 -: 8*DIO_BYTES];
  end

  always_comb begin : cmd_next
    freq_d  = freq_q;
    en_d    = en_q;
    sp_d    = sp_q;
    dout_d  = dout_q;
    good_d  = good_q;
    bad_d   = bad_q;
    estop_d = estop_q;
    if (good) begin
      freq_d = freq_rx;
      en_d   = en_rx;
      sp_d   = sp_rx;
      dout_d = dout_rx;
      good_d = good_q + 16'd1;
    end
    if (bad) bad_d = bad_q + 16'd1;
    // An asserted E-stop always wins over a clearing good frame.
    if (estop_in)  estop_d = 1'b1;
    else if (good) estop_d = 1'b0;
  end

  always_comb begin : tx_pack
    tx_body = '0;
    tx_body[BASE_BITS-1 -: 32] = swap32(estop_q ? RIO_TX_ESTOP : RIO_TX_DATA);
    for (int k = 0; k < JOINTS; k++)
      tx_body[BASE_BITS-1-32*(1+k) -: 32] = swap32(joint_feedback[32*k +: 32]);
    for (int k = 0; k < VINS; k++)
      tx_body[BASE_BITS-1-32*(1+JOINTS+k) -: 32] = swap32(process_var[32*k +: 32]);
    tx_body[TX_DIN_TOP-1 -: 8*DIO_BYTES] = din;
  end

`ifdef RIO_FRAME_CHECKSUM_EN
  assign tx_d = {tx_body, xor_bytes(RIO_XOR_BITS'(tx_body))};
`else
  assign tx_d = tx_body;
`endif

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      freq_q  <= '0;
      en_q    <= '0;
      sp_q    <= '0;
      dout_q  <= '0;
      good_q  <= '0;
      bad_q   <= '0;
      estop_q <= 1'b0;
      tx_q    <= '0;
    end else begin
      freq_q  <= freq_d;
      en_q    <= en_d;
      sp_q    <= sp_d;
      dout_q  <= dout_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      estop_q <= estop_d;
      if (!tx_lock) tx_q <= tx_d;
    end
  end

  rio_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i     (sysclk),
    .rst_ni    (rst_n),
    .clear_i   (good),
    .expired_o (wd_expired)
  );

  assign timeout        = wd_expired;
  assign error          = wd_expired | estop_q;
  assign joint_freq_cmd = freq_q;
  assign joint_enable   = en_q & ~{JOINTS{error}};
  assign setpoint       = error ? '0 : sp_q;
  assign dout           = dout_q;
  assign good_cnt       = good_q;
  assign bad_cnt        = bad_q;
  assign tx_frame       = tx_q;

endmodule

// File: tb/tb_rio_frame_codec.sv
// tb_rio_frame_codec: directed bench for rio_frame_codec (default channel counts,
// TIMEOUT_CYCLES=100). Frames are built as wire-ordered byte lists.
module tb_rio_frame_codec;

  localparam int J    = 5;
  localparam int VO   = 2;
  localparam int VI   = 1;
  localparam int DB   = 1;
  localparam int TO   = 100;
  localparam int EN_B = (J + 7) / 8;
  localparam int RXB  = 32*(1+J+VO) + 8*(EN_B+DB);
  localparam int TXB  = 32*(1+J+VI) + 8*DB;
  localparam int BASE = (((RXB > TXB) ? RXB : TXB) + 7) / 8 * 8;
`ifdef RIO_FRAME_CHECKSUM_EN
  localparam int FB = BASE + 8;
`else
  localparam int FB = BASE;
`endif
  localparam int NB = FB / 8;

  logic          sysclk = 1'b0;
  logic          rst_n;
  logic          frame_valid;
  logic [FB-1:0] rx_frame;
  logic          tx_lock;
  logic [FB-1:0] tx_frame;
  logic          estop_in;
  logic [32*J-1:0]  joint_feedback;
  logic [32*VI-1:0] process_var;
  logic [8*DB-1:0]  din;
  logic [32*J-1:0]  joint_freq_cmd;
  logic [J-1:0]     joint_enable;
  logic [32*VO-1:0] setpoint;
  logic [8*DB-1:0]  dout;
  logic          timeout, error;
  logic [15:0]   good_cnt, bad_cnt;

  rio_frame_codec #(
    .JOINTS(J), .VOUTS(VO), .VINS(VI), .DIO_BYTES(DB), .TIMEOUT_CYCLES(TO)
  ) dut (
    .sysclk(sysclk), .rst_n(rst_n), .frame_valid(frame_valid), .rx_frame(rx_frame),
    .tx_lock(tx_lock), .tx_frame(tx_frame), .estop_in(estop_in),
    .joint_feedback(joint_feedback), .process_var(process_var), .din(din),
    .joint_freq_cmd(joint_freq_cmd), .joint_enable(joint_enable), .setpoint(setpoint),
    .dout(dout), .timeout(timeout), .error(error), .good_cnt(good_cnt), .bad_cnt(bad_cnt)
  );

  always #5 sysclk = ~sysclk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  logic [7:0]    wb [NB];
  int            wp;
  logic [FB-1:0] tx_exp;

  task automatic clr_wb();
    for (int i = 0; i < NB; i++) wb[i] = 8'h00;
    wp = 0;
  endtask

  task automatic put32(input logic [31:0] v);
    wb[wp] = v[7:0]; wb[wp+1] = v[15:8]; wb[wp+2] = v[23:16]; wb[wp+3] = v[31:24];
    wp += 4;
  endtask

  task automatic seal();
`ifdef RIO_FRAME_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < NB - 1; i++) x ^= wb[i];
    wb[NB-1] = x;
`endif
  endtask

  function automatic logic [FB-1:0] pack_wb();
    logic [FB-1:0] f;
    f = '0;
    for (int i = 0; i < NB; i++) f[FB-1-8*i -: 8] = wb[i];
    return f;
  endfunction

  // Joints 1..4 carry their index; setpoint 1 is fixed.
  task automatic build_rx(input logic [31:0] hdr, input logic [31:0] j0, input logic [31:0] sp0,
                          input logic [4:0] en, input logic [7:0] dbyte);
    clr_wb();
    put32(hdr);
    put32(j0);
    for (int i = 1; i < J; i++) put32(32'(i));
    put32(sp0);
    put32(32'hCAFE0001);
    wb[wp] = {3'b000, en}; wp++;
    wb[wp] = dbyte; wp++;
    seal();
    rx_frame = pack_wb();
  endtask

  task automatic build_tx(input logic [31:0] hdr, input logic [31:0] fb0, input logic [31:0] fb1,
                          input logic [31:0] pv0, input logic [7:0] dbyte);
    clr_wb();
    put32(hdr);
    put32(fb0);
    put32(fb1);
    for (int i = 2; i < J; i++) put32(32'h0);
    put32(pv0);
    wb[wp] = dbyte; wp++;
    seal();
    tx_exp = pack_wb();
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic send_frame();
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
  endtask

  localparam logic [31:0] HDR_OK = 32'h74697277;

  initial begin
    rst_n = 1'b0; frame_valid = 1'b0; rx_frame = '0; tx_lock = 1'b0; estop_in = 1'b0;
    joint_feedback = '0; process_var = '0; din = '0;
    tick(); tick();
    chk("tx_in_reset", 320'(tx_frame), 320'(0));
    rst_n = 1'b1;
    tick();
    chk("rst_timeout", 320'(timeout), 320'(1));
    chk("rst_error", 320'(error), 320'(1));
    chk("rst_enable", 320'(joint_enable), 320'(0));
    chk("rst_good_cnt", 320'(good_cnt), 320'(0));
    chk("rst_tx_hdr", 320'(tx_frame[FB-1 -: 32]), 320'(32'h61746164));

    // First good frame
    build_rx(HDR_OK, 32'h00001234, 32'h0BADF00D, 5'b00011, 8'h5A);
    send_frame();
    chk("good_freq0", 320'(joint_freq_cmd[31:0]), 320'(32'h1234));
    chk("good_freq1", 320'(joint_freq_cmd[63:32]), 320'(32'h1));
    chk("good_enable", 320'(joint_enable), 320'(5'b00011));
    chk("good_sp0", 320'(setpoint[31:0]), 320'(32'h0BADF00D));
    chk("good_sp1", 320'(setpoint[63:32]), 320'(32'hCAFE0001));
    chk("good_dout", 320'(dout), 320'(8'h5A));
    chk("good_error", 320'(error), 320'(0));
    chk("good_cnt1", 320'(good_cnt), 320'(1));

    // Bad header: nothing commits, watchdog keeps running
    build_rx(32'h00000000, 32'h0000FFFF, 32'h0, 5'b11111, 8'hFF);
    send_frame();
    chk("bad_freq_hold", 320'(joint_freq_cmd[31:0]), 320'(32'h1234));
    chk("bad_enable_hold", 320'(joint_enable), 320'(5'b00011));
    chk("bad_cnt1", 320'(bad_cnt), 320'(1));
    chk("bad_good_cnt", 320'(good_cnt), 320'(1));
    repeat (TO - 2) tick();
    chk("wd_before", 320'(timeout), 320'(0));
    tick();
    chk("wd_expired", 320'(timeout), 320'(1));
    chk("wd_enable_gated", 320'(joint_enable), 320'(0));
    chk("wd_setpoint_zero", 320'(setpoint), 320'(0));
    chk("wd_freq_ungated", 320'(joint_freq_cmd[31:0]), 320'(32'h1234));

    // Recovery, then a good frame exactly on the expiry cycle
    build_rx(HDR_OK, 32'h00001234, 32'h0BADF00D, 5'b00011, 8'h5A);
    send_frame();
    chk("recover_timeout", 320'(timeout), 320'(0));
    repeat (TO - 1) tick();
    chk("edge_pre_timeout", 320'(timeout), 320'(0));
    send_frame();
    chk("edge_good_wins", 320'(timeout), 320'(0));
    chk("edge_good_cnt", 320'(good_cnt), 320'(3));

    // E-stop
    estop_in = 1'b1;
    tick();
    estop_in = 1'b0;
    chk("estop_error", 320'(error), 320'(1));
    chk("estop_enable", 320'(joint_enable), 320'(0));
    tick();
    chk("estop_tx_hdr", 320'(tx_frame[FB-1 -: 32]), 320'(32'h70747365));
    estop_in = 1'b1;
    send_frame();
    estop_in = 1'b0;
    chk("estop_held", 320'(error), 320'(1));
    chk("estop_good_cnt", 320'(good_cnt), 320'(4));
    send_frame();
    chk("estop_cleared", 320'(error), 320'(0));
    chk("estop_enable_back", 320'(joint_enable), 320'(5'b00011));
    tick();
    chk("estop_tx_data", 320'(tx_frame[FB-1 -: 32]), 320'(32'h61746164));

    // Transmit packing and hold
    joint_feedback = {32'h0, 32'h0, 32'h0, 32'h000000AB, 32'h11223344};
    process_var = 32'h55AA1234;
    din = 8'hC3;
    tick();
    build_tx(32'h64617461, 32'h11223344, 32'h000000AB, 32'h55AA1234, 8'hC3);
    chk("tx_frame", 320'(tx_frame), 320'(tx_exp));
    chk("tx_fb0_bytes", 320'(tx_frame[FB-33 -: 32]), 320'(32'h44332211));
    tx_lock = 1'b1;
    joint_feedback[31:0] = 32'hDEADBEEF;
    tick(); tick();
    chk("tx_lock_hold", 320'(tx_frame), 320'(tx_exp));
    build_rx(HDR_OK, 32'h00005678, 32'h0BADF00D, 5'b00101, 8'h5A);
    send_frame();
    chk("lock_rx_freq", 320'(joint_freq_cmd[31:0]), 320'(32'h5678));
    chk("lock_rx_enable", 320'(joint_enable), 320'(5'b00101));
    tx_lock = 1'b0;
    tick();
    build_tx(32'h64617461, 32'hDEADBEEF, 32'h000000AB, 32'h55AA1234, 8'hC3);
    chk("tx_unlock", 320'(tx_frame), 320'(tx_exp));

`ifdef RIO_FRAME_CHECKSUM_EN
    build_rx(HDR_OK, 32'h00009999, 32'h0, 5'b11111, 8'h00);
    rx_frame[7:0] = rx_frame[7:0] ^ 8'hFF;
    send_frame();
    chk("csum_bad_cnt", 320'(bad_cnt), 320'(2));
    chk("csum_freq_hold", 320'(joint_freq_cmd[31:0]), 320'(32'h5678));
    chk("csum_good_cnt", 320'(good_cnt), 320'(6));
`endif

    // Reset in the middle of a pending frame
    build_rx(HDR_OK, 32'h00007777, 32'h0, 5'b11111, 8'h00);
    frame_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_good_cnt", 320'(good_cnt), 320'(0));
    chk("arst_freq", 320'(joint_freq_cmd), 320'(0));
    chk("arst_timeout", 320'(timeout), 320'(1));
    chk("arst_tx", 320'(tx_frame), 320'(0));
    frame_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst_lost_frame", 320'(good_cnt), 320'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rio_frame_codec.md
# rio_frame_codec

Parametrised frame codec between the SPI slave buffer and the RIO channel blocks (joint_stepper, vout_pwm, vin_*). It validates each received frame's header, commits all command fields atomically, and runs a link watchdog and an E-stop latch that drive the global error. It also assembles the byte-swapped transmit frame from channel feedback. It replaces hand-written per-board rx/tx packing with one block sized by channel-count parameters.

## Interface
Parameters:
- JOINTS, 5, number of joint channels (1..16)
- VOUTS, 2, number of 32-bit setpoint outputs (0..16)
- VINS, 1, number of 32-bit process-variable inputs (0..16)
- DIO_BYTES, 1, bytes of digital out (rx) and digital in (tx)
- RX_HEADER, 32'h74697277, required rx header value
- TIMEOUT_CYCLES, 5000000, sysclk cycles without a good frame before timeout (≥2)
- Derived localparams: EN_BYTES=ceil(JOINTS/8); RX_BITS=32*(1+JOINTS+VOUTS)+8*(EN_BYTES+DIO_BYTES); TX_BITS=32*(1+JOINTS+VINS)+8*DIO_BYTES; FRAME_BITS=max(RX_BITS,TX_BITS) rounded up to a multiple of 8, plus 8 with the checksum option.

Ports:
- sysclk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- frame_valid  in  1  one-cycle pulse: rx_frame holds a complete frame
- rx_frame  in  FRAME_BITS  received frame, bit FRAME_BITS-1 first on wire
- tx_lock  in  1  high while SPI is shifting; tx_frame must hold
- tx_frame  out  FRAME_BITS  transmit frame
- estop_in  in  1  external E-stop request
- joint_feedback  in  32*JOINTS  joint i at [32i+31:32i]
- process_var  in  32*VINS  flat, same packing
- din  in  8*DIO_BYTES  digital inputs
- joint_freq_cmd  out  32*JOINTS  committed frequency commands
- joint_enable  out  JOINTS  committed enables, gated by error
- setpoint  out  32*VOUTS  committed setpoints, zeroed under error
- dout  out  8*DIO_BYTES  committed digital outputs
- timeout  out  1  watchdog expired
- error  out  1  timeout | estop latch
- good_cnt, bad_cnt  out  16 each  frame counters

## Operation
- Rx layout, MSB first: header, joint_freq_cmd[0..J-1], setpoint[0..V-1], enable bytes, dout bytes, zero pad. Every 32-bit field is sent low byte first: wire bytes v[7:0], v[15:8], v[23:16], v[31:24].
- In the enable field, joint i is bit i, LSB-aligned; the most-significant byte is sent first. Dout uses the same byte ordering.
- Tx layout: header, joint_feedback[0..], process_var[0..], din bytes, zero pad. Same byte swap.
- Tx header is 32'h65737470 while the estop latch is set, otherwise 32'h64617461.
- Good frame: frame_valid with header (after byte swap) equal to RX_HEADER.
  - All command registers load together.
  - Watchdog clears.
  - good_cnt increments.
- Bad frame: frame_valid with header mismatch.
  - Command registers hold.
  - Watchdog is not cleared.
  - bad_cnt increments.
- Counters wrap at 16'hFFFF to 0.
- Watchdog: counts up from 0 after a good frame and saturates at TIMEOUT_CYCLES. timeout = (count == TIMEOUT_CYCLES).
- Estop latch:
  - Set whenever estop_in is 1.
  - Cleared only by a good frame in a cycle where estop_in is 0.
- Gating: joint_enable = committed & ~error. setpoint = error ? 0 : committed. joint_freq_cmd and dout are not gated.
- Tx_frame re-registers from its inputs every cycle tx_lock is 0 and holds while tx_lock is 1.

## Timing
- Reset values:
  - All command outputs and counters 0.
  - Watchdog count = TIMEOUT_CYCLES, so timeout=1 and error=1 until the first good frame.
  - Estop latch 0.
  - tx_frame 0.
- Latency: frame_valid at edge n → command outputs, counters, timeout and error updated after edge n+1. Header compare is combinational on rx_frame.
- Tx: inputs sampled at edge n appear on tx_frame after edge n+1 (tx_lock 0).
- Simultaneous events:
  - Good frame in the same cycle the watchdog reaches TIMEOUT_CYCLES: the good frame wins and timeout is 0 next cycle.
  - Good frame with estop_in=1: the latch stays set.
  - frame_valid while tx_lock=1 is processed normally.
- Reset mid-frame: all state returns to reset values immediately; the pending frame is lost.

## Configuration
- RIO_FRAME_CHECKSUM_EN defined:
  - FRAME_BITS gains one trailing byte.
  - Rx: the trailing byte must equal the XOR of all preceding frame bytes; a mismatch makes the frame bad even if the header matches.
  - Tx: the trailing byte is the XOR of all preceding tx bytes.
- Undefined: no trailing byte, no checksum check.

## Structure
- Package rio_pkg:
  - Header constants (RX_HEADER default, TX data/estop words).
  - swap32 byte-swap function.
  - Byte-XOR reduction function.
- Sub-module rio_watchdog (saturating counter, clear input, expired output), parametrised by TIMEOUT_CYCLES.

## Test plan
- Reset release, no frames: timeout=1, error=1, joint_enable=0, tx header bytes 0x61,0x74,0x61,0x64 ("data" byte-swapped).
- Good frame, joint0 cmd 32'h00001234, enable 5'b00011 → joint_freq_cmd[31:0]=0x1234, joint_enable=00011, error=0, good_cnt=1 one cycle after frame_valid.
- Header 32'h00000000 frame after a good one → outputs unchanged, bad_cnt=1; TIMEOUT_CYCLES=100 and no further good frame → timeout=1 exactly 100 cycles after the last good frame, joint_enable=0, setpoint=0.
- estop_in pulsed 1 cycle → error=1, tx header bytes 0x70,0x74,0x73,0x65 ("estp" byte-swapped); a good frame with estop_in=0 clears it.
- tx_lock high, joint_feedback changed → tx_frame constant; tx_lock low → new value one cycle later. With RIO_FRAME_CHECKSUM_EN, a corrupted checksum byte → bad_cnt increments and outputs hold.
